// File: rtl/bt_seq_pkg.sv
// Shared types and default timing for the Bluetooth KEY/reset sequencer.
package bt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RST_HOLD = 2'd1,
    SETTLE   = 2'd2
  } bt_seq_state_e;

  localparam logic MODE_DATA = 1'b0;
  localparam logic MODE_AT   = 1'b1;

  // 1 ms reset pulse and 500 ms boot settle at 50 MHz
  localparam int unsigned DEF_RST_CYCLES    = 50000;
  localparam int unsigned DEF_SETTLE_CYCLES = 25000000;

endpackage

// File: rtl/bt_seq_timer.sv
// Loadable down-counter that stops at zero; zero flag is taken from the register.
module bt_seq_timer #(
  parameter int unsigned      CNT_W   = 32,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bt_key_sequencer.sv
// Drives the BT module reset and KEY pins through a timed re-boot whenever the requested mode changes.
module bt_key_sequencer
  import bt_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned CNT_W         = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_req,
  output logic bt_key,
  output logic bt_rst_n,
  output logic busy,
  output logic at_mode,
  output logic done
);

  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  bt_seq_state_e    state_q, state_d;
  logic             target_q, target_d;
  logic             at_mode_q, at_mode_d;
  logic             done_q, done_d;
  logic             bt_rst_n_q, bt_rst_n_d;
  logic             busy_q, busy_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_zero;

  bt_seq_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(RST_LOAD)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .load_val(tmr_load_val),
    .zero    (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    at_mode_d    = at_mode_q;
    done_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = RST_LOAD;
    unique case (state_q)
      IDLE: begin
        if (key_req != at_mode_q) begin
          target_d     = key_req;
          tmr_load     = 1'b1;
          tmr_load_val = RST_LOAD;
          state_d      = RST_HOLD;
        end
      end
      RST_HOLD: begin
        if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = SETTLE_LOAD;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          at_mode_d = target_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = RST_HOLD;
    endcase
    // Pin levels come from the next state so they are flop outputs, not decodes.
    bt_rst_n_d = (state_d != RST_HOLD);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RST_HOLD;
      target_q   <= MODE_DATA;
      at_mode_q  <= MODE_DATA;
      done_q     <= 1'b0;
      bt_rst_n_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      at_mode_q  <= at_mode_d;
      done_q     <= done_d;
      bt_rst_n_q <= bt_rst_n_d;
      busy_q     <= busy_d;
    end
  end

  assign bt_key   = target_q;
  assign bt_rst_n = bt_rst_n_q;
  assign busy     = busy_q;
  assign at_mode  = at_mode_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bt_key_sequencer.sv
// Self-checking bench for bt_key_sequencer with an elapsed-time reference model.
module tb_bt_key_sequencer;

  localparam int unsigned R = 4;
  localparam int unsigned S = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, key_req, bt_key, bt_rst_n, busy, at_mode, done;
  logic reset_b_n, key_b, bt_key_b, bt_rst_n_b, busy_b, at_mode_b, done_b;

  int checks   = 0;
  int failures = 0;

  bit m_busy;
  int m_elapsed;
  bit m_target;
  bit m_at;
  bit m_done;

  bt_key_sequencer #(
    .RST_CYCLES   (R),
    .SETTLE_CYCLES(S),
    .CNT_W        (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .key_req (key_req),
    .bt_key  (bt_key),
    .bt_rst_n(bt_rst_n),
    .busy    (busy),
    .at_mode (at_mode),
    .done    (done)
  );

  bt_key_sequencer #(
    .RST_CYCLES   (1),
    .SETTLE_CYCLES(1),
    .CNT_W        (4)
  ) dut_b (
    .clk     (clk),
    .reset_n (reset_b_n),
    .key_req (key_b),
    .bt_key  (bt_key_b),
    .bt_rst_n(bt_rst_n_b),
    .busy    (busy_b),
    .at_mode (at_mode_b),
    .done    (done_b)
  );

  task automatic model_reset();
    m_busy    = 1'b1;
    m_elapsed = 0;
    m_target  = 1'b0;
    m_at      = 1'b0;
    m_done    = 1'b0;
  endtask

  // A sequence lasts R+S cycles after the edge that starts it; done marks its end.
  task automatic model_step(input bit k);
    m_done = 1'b0;
    if (m_busy) begin
      m_elapsed++;
      if (m_elapsed == int'(R + S)) begin
        m_busy = 1'b0;
        m_at   = m_target;
        m_done = 1'b1;
      end
    end else if (k != m_at) begin
      m_busy    = 1'b1;
      m_elapsed = 0;
      m_target  = k;
    end
  endtask

  task automatic cycle();
    logic k;
    k = key_req;
    @(posedge clk);
    if (reset_n) model_step(k);
    #1;
  endtask

  task automatic wait_done(input int limit, output int n, output bit got);
    n   = 0;
    got = 1'b0;
    while (!got && n < limit) begin
      cycle();
      n++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    reset_b_n = 1'b0;
    key_req   = 1'b0;
    key_b     = 1'b0;
    model_reset();
    repeat (3) cycle();
    checks++; if (bt_rst_n !== 1'b0) begin failures++; $display("FAIL reset_bt_rst_n got=%b exp=0", bt_rst_n); end
    checks++; if (busy !== 1'b1)     begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (bt_key !== 1'b0)   begin failures++; $display("FAIL reset_bt_key got=%b exp=0", bt_key); end
    checks++; if (at_mode !== 1'b0)  begin failures++; $display("FAIL reset_at_mode got=%b exp=0", at_mode); end
    checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    reset_n   = 1'b1;
    reset_b_n = 1'b1;
  endtask

  task automatic check_boot_sequence(input string tag);
    int low = 0, hi_busy = 0, n = 0, extra = 0;
    bit got = 1'b0;
    if (!bt_rst_n) low++;
    while (!got && n < 100) begin
      cycle();
      n++;
      if (done) got = 1'b1;
      else if (!bt_rst_n) low++;
      else if (busy) hi_busy++;
    end
    checks++; if (!got)         begin failures++; $display("FAIL %s_done_timeout cycles=%0d", tag, n); end
    checks++; if (low != R)     begin failures++; $display("FAIL %s_rst_low got=%0d exp=%0d", tag, low, R); end
    checks++; if (hi_busy != S) begin failures++; $display("FAIL %s_settle got=%0d exp=%0d", tag, hi_busy, S); end
    checks++; if (busy !== 1'b0 || at_mode !== 1'b0) begin
      failures++; $display("FAIL %s_end busy=%b at_mode=%b exp busy=0 at_mode=0", tag, busy, at_mode);
    end
    repeat (5) begin cycle(); if (done) extra++; end
    checks++; if (extra != 0)   begin failures++; $display("FAIL %s_extra_done got=%0d exp=0", tag, extra); end
  endtask

  task automatic test_power_on();
    check_boot_sequence("power_on");
  endtask

  task automatic test_at_entry();
    int n = 1, first_hi = 0;
    key_req = 1'b1;
    cycle();
    checks++; if (bt_key !== 1'b1 || bt_rst_n !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL at_start key=%b rst_n=%b busy=%b exp 1 0 1", bt_key, bt_rst_n, busy);
    end
    while (!done && n < 100) begin
      cycle();
      n++;
      if (bt_rst_n && first_hi == 0) first_hi = n;
    end
    checks++; if (n != int'(1 + R + S)) begin failures++; $display("FAIL at_latency got=%0d exp=%0d", n, 1 + R + S); end
    checks++; if (first_hi != int'(R + 1)) begin failures++; $display("FAIL at_rst_release got=%0d exp=%0d", first_hi, R + 1); end
    checks++; if (at_mode !== 1'b1) begin failures++; $display("FAIL at_mode got=%b exp=1", at_mode); end
    repeat (3) cycle();
    checks++; if (bt_key !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL at_hold key=%b busy=%b exp 1 0", bt_key, busy);
    end
  endtask

  task automatic test_mid_toggle();
    int n;
    bit got;
    key_req = 1'b0;
    wait_done(100, n, got);
    checks++; if (!got || at_mode !== 1'b0) begin failures++; $display("FAIL toggle_setup got=%b at_mode=%b exp 1 0", got, at_mode); end
    key_req = 1'b1;
    repeat (2) cycle();
    key_req = 1'b0;
    wait_done(100, n, got);
    checks++; if (!got || at_mode !== 1'b1) begin failures++; $display("FAIL toggle_first got=%b at_mode=%b exp 1 1", got, at_mode); end
    cycle();
    checks++; if (busy !== 1'b1 || bt_key !== 1'b0 || bt_rst_n !== 1'b0) begin
      failures++; $display("FAIL toggle_restart busy=%b key=%b rst_n=%b exp 1 0 0", busy, bt_key, bt_rst_n);
    end
    wait_done(100, n, got);
    checks++; if (!got || at_mode !== 1'b0) begin failures++; $display("FAIL toggle_second got=%b at_mode=%b exp 1 0", got, at_mode); end
  endtask

  task automatic test_glitch();
    int n, dones = 0;
    bit got;
    key_req = 1'b1;
    wait_done(100, n, got);
    checks++; if (!got || at_mode !== 1'b1) begin failures++; $display("FAIL glitch_setup got=%b at_mode=%b exp 1 1", got, at_mode); end
    key_req = 1'b0;
    repeat (3) begin cycle(); if (done) dones++; end
    key_req = 1'b1;
    repeat (2) begin cycle(); if (done) dones++; end
    key_req = 1'b0;
    repeat (30) begin cycle(); if (done) dones++; end
    checks++; if (dones != 1) begin failures++; $display("FAIL glitch_dones got=%0d exp=1", dones); end
    checks++; if (at_mode !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL glitch_end at_mode=%b busy=%b exp 0 0", at_mode, busy);
    end
  endtask

  task automatic test_reset_mid_settle();
    key_req = 1'b1;
    repeat (8) cycle();
    checks++; if (busy !== 1'b1 || bt_rst_n !== 1'b1 || bt_key !== 1'b1) begin
      failures++; $display("FAIL settle_pre busy=%b rst_n=%b key=%b exp 1 1 1", busy, bt_rst_n, bt_key);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bt_rst_n !== 1'b0 || bt_key !== 1'b0 || at_mode !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL settle_reset rst_n=%b key=%b at=%b done=%b busy=%b exp 0 0 0 0 1",
                           bt_rst_n, bt_key, at_mode, done, busy);
    end
    key_req = 1'b0;
    repeat (2) cycle();
    reset_n = 1'b1;
    check_boot_sequence("settle_reboot");
  endtask

  task automatic test_random();
    bit exp_rst_n;
    for (int unsigned i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) key_req = ~key_req;
      cycle();
      exp_rst_n = !(m_busy && m_elapsed < int'(R));
      checks++; if (bt_rst_n !== exp_rst_n) begin failures++; $display("FAIL rand_rst_n i=%0d got=%b exp=%b", i, bt_rst_n, exp_rst_n); end
      checks++; if (busy !== m_busy)        begin failures++; $display("FAIL rand_busy i=%0d got=%b exp=%b", i, busy, m_busy); end
      checks++; if (bt_key !== m_target)    begin failures++; $display("FAIL rand_key i=%0d got=%b exp=%b", i, bt_key, m_target); end
      checks++; if (at_mode !== m_at)       begin failures++; $display("FAIL rand_at i=%0d got=%b exp=%b", i, at_mode, m_at); end
      checks++; if (done !== m_done)        begin failures++; $display("FAIL rand_done i=%0d got=%b exp=%b", i, done, m_done); end
    end
  endtask

  task automatic test_boundary();
    for (int unsigned v = 0; v < 2; v++) begin
      int n = 0, low = 0, extra = 0;
      key_b = (v == 0) ? 1'b1 : 1'b0;
      while (!done_b && n < 20) begin
        cycle();
        n++;
        if (!bt_rst_n_b) low++;
      end
      checks++; if (n != 3)   begin failures++; $display("FAIL bnd_latency v=%0d got=%0d exp=3", v, n); end
      checks++; if (low != 1) begin failures++; $display("FAIL bnd_rst_low v=%0d got=%0d exp=1", v, low); end
      checks++; if (at_mode_b !== key_b || bt_key_b !== key_b) begin
        failures++; $display("FAIL bnd_mode v=%0d at=%b key=%b exp=%b", v, at_mode_b, bt_key_b, key_b);
      end
      repeat (6) begin cycle(); if (done_b) extra++; end
      checks++; if (extra != 0 || busy_b !== 1'b0) begin
        failures++; $display("FAIL bnd_extra v=%0d dones=%0d busy=%b exp 0 0", v, extra, busy_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_at_entry();
    test_mid_toggle();
    test_glitch();
    test_reset_mid_settle();
    test_random();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
